// File: rtl/sobel_janela_3x3_if.sv
// Pixel-in / window-out bundle between the serial receiver, the window generator
// and the Sobel kernel.
interface sobel_janela_3x3_if #(
  parameter int LARGURA = 64,
  parameter int ALTURA  = 64
);
  logic                         rx_pronto;
  logic [7:0]                   rx_dados;
  logic                         limpa;
  logic [71:0]                  janela;
  logic                         janela_valida;
  logic [$clog2(ALTURA)-1:0]    centro_linha;
  logic [$clog2(LARGURA)-1:0]   centro_coluna;
  logic                         fim_imagem;
  logic                         db_estado;

  modport master (
    output rx_pronto, rx_dados, limpa,
    input  janela, janela_valida, centro_linha, centro_coluna, fim_imagem, db_estado
  );

  modport slave (
    input  rx_pronto, rx_dados, limpa,
    output janela, janela_valida, centro_linha, centro_coluna, fim_imagem, db_estado
  );
endinterface

// File: rtl/sobel_janela_3x3.sv
// 3x3 window generator: two line buffers plus a 3x3 shift register, emitting one
// registered window per pixel that completes a full neighbourhood.
module sobel_janela_3x3 #(
  parameter int LARGURA = 64,
  parameter int ALTURA  = 64
) (
  input  logic              clock,
  input  logic              reset,
  sobel_janela_3x3_if.slave bus
);

  localparam int LW = $clog2(LARGURA);
  localparam int AW = $clog2(ALTURA);
  localparam logic [LW-1:0] ULTIMA_COLUNA = LW'(LARGURA - 1);
  localparam logic [AW-1:0] ULTIMA_LINHA  = AW'(ALTURA - 1);

  typedef enum logic {
    PREENCHE = 1'b0,
    PROCESSA = 1'b1
  } estado_t;

  estado_t         estado;
  logic [LW-1:0]   coluna;
  logic [AW-1:0]   linha;
  logic [7:0]      buf_a [LARGURA];
  logic [7:0]      buf_b [LARGURA];
  logic [71:0]     deslocador;
  logic [71:0]     janela_prox;
  logic [71:0]     janela_reg;
  logic            valida_reg;
  logic            fim_reg;
  logic [AW-1:0]   centro_linha_reg;
  logic [LW-1:0]   centro_coluna_reg;
  logic [7:0]      lido_a;
  logic [7:0]      lido_b;
  logic            aceita;
  logic            fim_coluna;
  logic            fim_linha;
  logic            emite;

  // limpa dominates rx_pronto, so a pixel arriving with it is simply dropped
  assign aceita     = bus.rx_pronto && !bus.limpa;
  assign fim_coluna = (coluna == ULTIMA_COLUNA);
  assign fim_linha  = (linha == ULTIMA_LINHA);
  assign emite      = aceita && (linha >= AW'(2)) && (coluna >= LW'(2));

  assign lido_a = buf_a[coluna];
  assign lido_b = buf_b[coluna];

  // Shift left one column; the new right column is {row y-2, row y-1, row y}
  assign janela_prox = {deslocador[63:48], lido_b,
                        deslocador[39:24], lido_a,
                        deslocador[15:0],  bus.rx_dados};

  // Line buffers behave as RAM: never reset, contents only meaningful once refilled
  always_ff @(posedge clock) begin
    if (aceita) begin
      buf_b[coluna] <= lido_a;
      buf_a[coluna] <= bus.rx_dados;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado            <= PREENCHE;
      linha             <= '0;
      coluna            <= '0;
      deslocador        <= '0;
      janela_reg        <= '0;
      valida_reg        <= 1'b0;
      fim_reg           <= 1'b0;
      centro_linha_reg  <= '0;
      centro_coluna_reg <= '0;
    end else begin
      valida_reg <= 1'b0;
      fim_reg    <= 1'b0;
      if (bus.limpa) begin
        estado <= PREENCHE;
        linha  <= '0;
        coluna <= '0;
      end else if (aceita) begin
        deslocador <= janela_prox;
        if (emite) begin
          janela_reg        <= janela_prox;
          valida_reg        <= 1'b1;
          centro_linha_reg  <= linha - AW'(1);
          centro_coluna_reg <= coluna - LW'(1);
          fim_reg           <= fim_linha && fim_coluna;
        end
        if (fim_coluna) begin
          coluna <= '0;
          linha  <= fim_linha ? '0 : linha + AW'(1);
          if (linha == AW'(1)) begin
            estado <= PROCESSA;
          end else if (fim_linha) begin
            estado <= PREENCHE;
          end
        end else begin
          coluna <= coluna + LW'(1);
        end
      end
    end
  end

  assign bus.janela        = janela_reg;
  assign bus.janela_valida = valida_reg;
  assign bus.centro_linha  = centro_linha_reg;
  assign bus.centro_coluna = centro_coluna_reg;
  assign bus.fim_imagem    = fim_reg;
  assign bus.db_estado     = (estado == PROCESSA);

endmodule
